// File: rtl/processor_display_select.sv
// rtl/processor_display_select.sv - display source selector with manual step, auto-rotate and freeze
module processor_display_select #(
  parameter int WIDTH         = 32,
  parameter int NUM_CH        = 4,
  parameter int ROTATE_CYCLES = 50_000_000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*WIDTH-1:0]     ch_data,
  input  logic                        step_btn,
  input  logic                        auto_en,
  input  logic                        freeze,
  output logic [WIDTH-1:0]            seg_out,
  output logic [$clog2(NUM_CH)-1:0]   ch_idx,
  output logic                        upd
);

  localparam int IW = $clog2(NUM_CH);
  localparam int CW = (ROTATE_CYCLES > 2) ? $clog2(ROTATE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ROTATE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   btn_q;
  logic                   armed_q;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          shown_q;
  logic                   step;
  logic                   term;
  logic                   adv;
  logic [IW-1:0]          nxt_idx;
  logic [WIDTH-1:0]       ch_arr [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_arr[k] = ch_data[k*WIDTH +: WIDTH];
  end

  // vld_q marks when the chain holds real samples; arming needs a genuine low
  // level first, so a button held through reset release never produces a step.
  assign step    = armed_q & sync_q[SYNC_STAGES-1] & ~btn_q;
  assign term    = auto_en & (cnt_q == CNT_LAST);
  assign adv     = ~freeze & (step | term);
  assign nxt_idx = (ch_idx == IDX_LAST) ? '0 : ch_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], step_btn};
      vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      btn_q   <= sync_q[SYNC_STAGES-1];
      armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!freeze) begin
      if (!auto_en || adv) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // shown_q is the channel currently on seg_out; upd fires when that changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_idx  <= '0;
      shown_q <= '0;
      seg_out <= '0;
      upd     <= 1'b0;
    end else if (freeze) begin
      upd <= 1'b0;
    end else begin
      seg_out <= ch_arr[ch_idx];
      shown_q <= ch_idx;
      upd     <= (ch_idx != shown_q);
      if (adv) begin
        ch_idx <= nxt_idx;
      end
    end
  end

endmodule
